// File: rtl/chaves_debouncer.sv
// Switch input conditioner: 2-FF synchronizer plus per-bit tick-based debounce
// filter, with registered rise/fall pulses and a summary change strobe.
module chaves_debouncer #(
  parameter int WIDTH        = 10,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10,
  parameter int DIV_W        = 16,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] debounced_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed
);

  logic [WIDTH-1:0]            r_sync1;
  logic [WIDTH-1:0]            r_sync2;
  logic [DIV_W-1:0]            r_div;
  logic                        w_tick;
  logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0][CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]            w_toggle;
  logic [WIDTH-1:0]            r_deb;
  logic [WIDTH-1:0]            r_rise;
  logic [WIDTH-1:0]            r_fall;
  logic                        r_changed;

  assign w_tick        = (r_div == DIV_W'(TICK_DIV - 1));
  assign debounced_out = r_deb;
  assign rise_pulse    = r_rise;
  assign fall_pulse    = r_fall;
  assign changed       = r_changed;

  // Two-stage synchronizer, no logic between the stages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= {WIDTH{1'b0}};
      r_sync2 <= {WIDTH{1'b0}};
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running tick prescaler shared by all bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= {DIV_W{1'b0}};
    end else if (w_tick) begin
      r_div <= {DIV_W{1'b0}};
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Per-bit filter: a match always clears, so a tick never outranks a match
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_toggle  = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (r_sync2[i] == r_deb[i]) begin
        w_cnt_nxt[i] = {CNT_W{1'b0}};
      end else if (w_tick) begin
        if (r_cnt[i] == CNT_W'(STABLE_TICKS - 1)) begin
          w_toggle[i]  = 1'b1;
          w_cnt_nxt[i] = {CNT_W{1'b0}};
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
    end
  end

  // Counter state and registered outputs, updated at the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= {(WIDTH*CNT_W){1'b0}};
      r_deb     <= {WIDTH{1'b0}};
      r_rise    <= {WIDTH{1'b0}};
      r_fall    <= {WIDTH{1'b0}};
      r_changed <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_deb     <= r_deb ^ w_toggle;
      r_rise    <= w_toggle & ~r_deb;
      r_fall    <= w_toggle & r_deb;
      r_changed <= |w_toggle;
    end
  end

endmodule
